// File: rtl/axi_wr_req_sequencer_if.sv
// ---------------------------------------------------------------------------
// axi_wr_req_sequencer_if
//
// Bundles every non-clock/non-reset signal of axi_wr_req_sequencer.
//   slave  modport : the sequencer's own view (used as its port).
//   master modport : the environment's view (user side + AXI master side).
//
// Signal groups:
//   cmd_*            user write-command push (valid/ready)
//   wd_*             user write-data push (valid/ready)
//   aw*_d, TXN_ID_W_d, wdata_d, wstrb_d, wr_trn_en
//                    transaction fields and start pulse toward the AXI master
//   WVALID, WREADY   W-channel taps used to advance data beats
//   bresp_d, bid_d, wr_rsp_en_d
//                    write response captured from the AXI master
//   rsp_*            response FIFO pop toward the user
//   busy, rsp_ovf    status
//   timeout_err      present only when AXI_WR_SEQ_TIMEOUT_EN is defined
// ---------------------------------------------------------------------------
interface axi_wr_req_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_id;
  logic [1:0]            cmd_burst;
  logic [3:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic [1:0]            cmd_lock;
  logic [1:0]            cmd_cache;
  logic [2:0]            cmd_prot;

  logic                  wd_valid;
  logic                  wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [STRB_WIDTH-1:0] wd_strb;

  logic [ADDR_WIDTH-1:0] awaddr_d;
  logic [3:0]            TXN_ID_W_d;
  logic [1:0]            awburst_d;
  logic [3:0]            awlen_d;
  logic [2:0]            awsize_d;
  logic [1:0]            awlock_d;
  logic [1:0]            awcache_d;
  logic [2:0]            awprot_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_d;
  logic                  wr_trn_en;

  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            bresp_d;
  logic [3:0]            bid_d;
  logic                  wr_rsp_en_d;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [3:0]            rsp_id;
  logic [1:0]            rsp_resp;

  logic                  busy;
  logic                  rsp_ovf;
`ifdef AXI_WR_SEQ_TIMEOUT_EN
  logic                  timeout_err;
`endif

  modport slave (
    input  cmd_valid, cmd_addr, cmd_id, cmd_burst, cmd_len, cmd_size,
           cmd_lock, cmd_cache, cmd_prot,
           wd_valid, wd_data, wd_strb,
           WVALID, WREADY, bresp_d, bid_d, wr_rsp_en_d, rsp_ready,
    output cmd_ready, wd_ready,
           awaddr_d, TXN_ID_W_d, awburst_d, awlen_d, awsize_d, awlock_d,
           awcache_d, awprot_d, wdata_d, wstrb_d, wr_trn_en,
           rsp_valid, rsp_id, rsp_resp, busy, rsp_ovf
`ifdef AXI_WR_SEQ_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_id, cmd_burst, cmd_len, cmd_size,
           cmd_lock, cmd_cache, cmd_prot,
           wd_valid, wd_data, wd_strb,
           WVALID, WREADY, bresp_d, bid_d, wr_rsp_en_d, rsp_ready,
    input  cmd_ready, wd_ready,
           awaddr_d, TXN_ID_W_d, awburst_d, awlen_d, awsize_d, awlock_d,
           awcache_d, awprot_d, wdata_d, wstrb_d, wr_trn_en,
           rsp_valid, rsp_id, rsp_resp, busy, rsp_ovf
`ifdef AXI_WR_SEQ_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/axi_wr_req_sequencer.sv
// ---------------------------------------------------------------------------
// axi_wr_req_sequencer
//
// Upstream feeder for the AXI master write-control stage. Write commands and
// write-data beats are buffered in two synchronous FIFOs; one transaction at
// a time is handed to the master (fields + wr_trn_en pulse), data beats are
// retired on observed W handshakes, and the master's write response is
// queued in a response FIFO for the user.
//
// Ports:
//   AClk  rising-edge clock
//   ARst  synchronous, active-low reset
//   bus   axi_wr_req_sequencer_if.slave (command/data push, master-side
//         fields, W taps, response capture, response pop, status)
//
// Optional feature (macro AXI_WR_SEQ_TIMEOUT_EN): 16-bit watchdog over
// BURST/WAIT_RSP; on expiry the head command is retired with a synthesized
// SLVERR response, its remaining beats are flushed, and the sticky
// timeout_err output is raised. Undefined by default: no watchdog.
// ---------------------------------------------------------------------------
module axi_wr_req_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input logic                   AClk,
  input logic                   ARst,
  axi_wr_req_sequencer_if.slave bus
);
  localparam int CAW   = $clog2(CMD_DEPTH);
  localparam int DAW   = $clog2(DATA_DEPTH);
  localparam int RAW   = $clog2(RSP_DEPTH);
  localparam int CMD_W = ADDR_WIDTH + 20;
  localparam int WD_W  = DATA_WIDTH + STRB_WIDTH;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DATA = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_BURST     = 3'd3;
  localparam logic [2:0] S_WAIT_RSP  = 3'd4;
`ifdef AXI_WR_SEQ_TIMEOUT_EN
  localparam logic [2:0] S_FLUSH     = 3'd5;
`endif

  logic [2:0] state, state_nxt;
  logic [4:0] beat_cnt, beat_nxt;
  logic       hs;
  logic       cmd_pop_req, wd_pop_req, rsp_push_req;
  logic [5:0] rsp_push_data;

  assign hs = bus.WVALID && bus.WREADY;

  // Command FIFO
  logic [CMD_W-1:0]      cmd_mem [CMD_DEPTH];
  logic [CAW-1:0]        cmd_wptr, cmd_rptr;
  logic [CAW:0]          cmd_count;
  logic                  cmd_push, cmd_pop;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [3:0]            head_id, head_len;
  logic [1:0]            head_burst, head_lock, head_cache;
  logic [2:0]            head_size, head_prot;

  assign bus.cmd_ready = (cmd_count != (CAW+1)'(CMD_DEPTH));
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
  assign cmd_pop       = cmd_pop_req && (cmd_count != '0);
  assign {head_addr, head_id, head_burst, head_len, head_size,
          head_lock, head_cache, head_prot} = cmd_mem[cmd_rptr];

  always_ff @(posedge AClk) begin
    if (cmd_push)
      cmd_mem[cmd_wptr] <= {bus.cmd_addr, bus.cmd_id, bus.cmd_burst, bus.cmd_len,
                            bus.cmd_size, bus.cmd_lock, bus.cmd_cache, bus.cmd_prot};
  end

  always_ff @(posedge AClk) begin
    if (!ARst) begin
      cmd_wptr  <= '0;
      cmd_rptr  <= '0;
      cmd_count <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + CAW'(1);
      if (cmd_pop)  cmd_rptr <= cmd_rptr + CAW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + (CAW+1)'(1);
        2'b01:   cmd_count <= cmd_count - (CAW+1)'(1);
        default: ;
      endcase
    end
  end

  // Write-data FIFO
  logic [WD_W-1:0] wd_mem [DATA_DEPTH];
  logic [DAW-1:0]  wd_wptr, wd_rptr;
  logic [DAW:0]    wd_count, wd_need;
  logic            wd_push, wd_pop;
  logic [WD_W-1:0] wd_head;

  assign bus.wd_ready = (wd_count != (DAW+1)'(DATA_DEPTH));
  assign wd_push      = bus.wd_valid && bus.wd_ready;
  assign wd_pop       = wd_pop_req && (wd_count != '0);
  assign wd_need      = (DAW+1)'(head_len) + (DAW+1)'(1);

  // Empty FIFO presents zeros so the master never sees stale or reset-less
  // storage contents.
  assign wd_head     = (wd_count != '0) ? wd_mem[wd_rptr] : '0;
  assign bus.wdata_d = wd_head[WD_W-1:STRB_WIDTH];
  assign bus.wstrb_d = wd_head[STRB_WIDTH-1:0];

  always_ff @(posedge AClk) begin
    if (wd_push) wd_mem[wd_wptr] <= {bus.wd_data, bus.wd_strb};
  end

  always_ff @(posedge AClk) begin
    if (!ARst) begin
      wd_wptr  <= '0;
      wd_rptr  <= '0;
      wd_count <= '0;
    end else begin
      if (wd_push) wd_wptr <= wd_wptr + DAW'(1);
      if (wd_pop)  wd_rptr <= wd_rptr + DAW'(1);
      case ({wd_push, wd_pop})
        2'b10:   wd_count <= wd_count + (DAW+1)'(1);
        2'b01:   wd_count <= wd_count - (DAW+1)'(1);
        default: ;
      endcase
    end
  end

  // Response FIFO
  logic [5:0]     rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wptr, rsp_rptr;
  logic [RAW:0]   rsp_count;
  logic           rsp_full, rsp_push, rsp_pop, ovf_set;
  logic [5:0]     rsp_head;

  // A full FIFO drops the response even if the user pops in the same cycle;
  // the drop decision depends only on registered occupancy.
  assign rsp_full      = (rsp_count == (RAW+1)'(RSP_DEPTH));
  assign rsp_push      = rsp_push_req && !rsp_full;
  assign ovf_set       = rsp_push_req && rsp_full;
  assign bus.rsp_valid = (rsp_count != '0);
  assign rsp_pop       = bus.rsp_ready && bus.rsp_valid;
  assign rsp_head      = bus.rsp_valid ? rsp_mem[rsp_rptr] : '0;
  assign bus.rsp_id    = rsp_head[5:2];
  assign bus.rsp_resp  = rsp_head[1:0];

  always_ff @(posedge AClk) begin
    if (rsp_push) rsp_mem[rsp_wptr] <= rsp_push_data;
  end

  always_ff @(posedge AClk) begin
    if (!ARst) begin
      rsp_wptr  <= '0;
      rsp_rptr  <= '0;
      rsp_count <= '0;
    end else begin
      if (rsp_push) rsp_wptr <= rsp_wptr + RAW'(1);
      if (rsp_pop)  rsp_rptr <= rsp_rptr + RAW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + (RAW+1)'(1);
        2'b01:   rsp_count <= rsp_count - (RAW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef AXI_WR_SEQ_TIMEOUT_EN
  logic [15:0] wdog;
  logic        wdog_fire;
  assign wdog_fire = (wdog == 16'hFFFF) &&
                     (((state == S_BURST) && !hs) ||
                      ((state == S_WAIT_RSP) && !bus.wr_rsp_en_d));
`endif

  // Sequencing FSM
  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat_cnt;
    cmd_pop_req   = 1'b0;
    wd_pop_req    = 1'b0;
    rsp_push_req  = 1'b0;
    rsp_push_data = {bus.bid_d, bus.bresp_d};
    case (state)
      S_IDLE:      if (cmd_count != '0) state_nxt = S_WAIT_DATA;
      // Whole burst must be buffered before issue; no partial bursts.
      S_WAIT_DATA: if (wd_count >= wd_need) state_nxt = S_ISSUE;
      S_ISSUE: begin
        beat_nxt  = {1'b0, head_len} + 5'd1;
        state_nxt = S_BURST;
      end
      S_BURST: begin
        if (hs) begin
          wd_pop_req = 1'b1;
          beat_nxt   = beat_cnt - 5'd1;
          if (beat_cnt == 5'd1) state_nxt = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (bus.wr_rsp_en_d) begin
          cmd_pop_req  = 1'b1;
          rsp_push_req = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
`ifdef AXI_WR_SEQ_TIMEOUT_EN
      S_FLUSH: begin
        wd_pop_req = 1'b1;
        beat_nxt   = beat_cnt - 5'd1;
        if (beat_cnt <= 5'd1) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
`ifdef AXI_WR_SEQ_TIMEOUT_EN
    // Watchdog expiry overrides normal progress: retire the command with a
    // synthesized SLVERR and discard whatever beats it still owns.
    if (wdog_fire) begin
      cmd_pop_req   = 1'b1;
      rsp_push_req  = 1'b1;
      wd_pop_req    = 1'b0;
      beat_nxt      = beat_cnt;
      rsp_push_data = {head_id, 2'b10};
      state_nxt     = (beat_cnt != 5'd0) ? S_FLUSH : S_IDLE;
    end
`endif
  end

  logic hold_cmd;
  assign hold_cmd      = (state_nxt == S_ISSUE) || (state_nxt == S_BURST) ||
                         (state_nxt == S_WAIT_RSP);
  assign bus.wr_trn_en = (state == S_ISSUE);
  assign bus.busy      = (state != S_IDLE);

  always_ff @(posedge AClk) begin
    if (!ARst) begin
      state          <= S_IDLE;
      beat_cnt       <= '0;
      bus.rsp_ovf    <= 1'b0;
      bus.awaddr_d   <= '0;
      bus.TXN_ID_W_d <= '0;
      bus.awburst_d  <= '0;
      bus.awlen_d    <= '0;
      bus.awsize_d   <= '0;
      bus.awlock_d   <= '0;
      bus.awcache_d  <= '0;
      bus.awprot_d   <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      if (ovf_set) bus.rsp_ovf <= 1'b1;
      // Head stays put until the command is popped, so reloading every
      // cycle while the transaction is live keeps the fields stable.
      bus.awaddr_d   <= hold_cmd ? head_addr  : '0;
      bus.TXN_ID_W_d <= hold_cmd ? head_id    : '0;
      bus.awburst_d  <= hold_cmd ? head_burst : '0;
      bus.awlen_d    <= hold_cmd ? head_len   : '0;
      bus.awsize_d   <= hold_cmd ? head_size  : '0;
      bus.awlock_d   <= hold_cmd ? head_lock  : '0;
      bus.awcache_d  <= hold_cmd ? head_cache : '0;
      bus.awprot_d   <= hold_cmd ? head_prot  : '0;
    end
  end

`ifdef AXI_WR_SEQ_TIMEOUT_EN
  always_ff @(posedge AClk) begin
    if (!ARst) begin
      wdog            <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      if (wdog_fire) bus.timeout_err <= 1'b1;
      if ((state == S_ISSUE) || ((state == S_BURST) && hs))
        wdog <= '0;
      else if ((state == S_BURST) || (state == S_WAIT_RSP))
        wdog <= (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;
      else
        wdog <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_req_sequencer
//
// Scoreboard bench: commands, beats and responses are queued as expected
// values when driven; a negedge monitor pops the command queue on every
// wr_trn_en pulse, the W-channel model pops beats on handshakes, and the user
// side pops responses.
// ---------------------------------------------------------------------------
module tb_axi_wr_req_sequencer;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int RSP_DEPTH = 4;

  logic AClk;
  logic ARst;

  axi_wr_req_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  axi_wr_req_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .CMD_DEPTH(4), .DATA_DEPTH(32), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .AClk(AClk),
    .ARst(ARst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    id;
    logic [1:0]    burst;
    logic [3:0]    len;
    logic [2:0]    size;
    logic [1:0]    lock;
    logic [1:0]    cache;
    logic [2:0]    prot;
  } cmd_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } beat_t;

  cmd_t       exp_cmd_q[$];
  cmd_t       issued_q[$];
  beat_t      exp_beat_q[$];
  logic [5:0] exp_rsp_q[$];
  cmd_t       mon_c;
  int         n_chk = 0;
  int         n_fail = 0;
  int         trn_cnt = 0;
  logic       exp_ovf = 1'b0;

  initial AClk = 1'b0;
  always #5 AClk = ~AClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AClk);
    #1;
  endtask

  // Every start pulse must match the oldest command not yet issued.
  always @(negedge AClk) begin
    if (bus.wr_trn_en === 1'b1) begin
      trn_cnt++;
      if (exp_cmd_q.size() == 0) begin
        chk("trn_unexpected", 64'(1), 64'(0));
      end else begin
        mon_c = exp_cmd_q.pop_front();
        chk("awaddr",  64'(bus.awaddr_d),   64'(mon_c.addr));
        chk("awid",    64'(bus.TXN_ID_W_d), 64'(mon_c.id));
        chk("awburst", 64'(bus.awburst_d),  64'(mon_c.burst));
        chk("awlen",   64'(bus.awlen_d),    64'(mon_c.len));
        chk("awsize",  64'(bus.awsize_d),   64'(mon_c.size));
        chk("awlock",  64'(bus.awlock_d),   64'(mon_c.lock));
        chk("awcache", 64'(bus.awcache_d),  64'(mon_c.cache));
        chk("awprot",  64'(bus.awprot_d),   64'(mon_c.prot));
        issued_q.push_back(mon_c);
      end
    end
  end

  function automatic cmd_t mk_cmd(input logic [AW-1:0] a, input logic [3:0] id,
                                  input logic [3:0] len);
    cmd_t c;
    c.addr  = a;
    c.id    = id;
    c.burst = 2'b01;
    c.len   = len;
    c.size  = 3'd3;
    c.lock  = id[1:0];
    c.cache = ~id[1:0];
    c.prot  = id[2:0];
    return c;
  endfunction

  task automatic push_cmd(input cmd_t c);
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = c.addr;
    bus.cmd_id    = c.id;
    bus.cmd_burst = c.burst;
    bus.cmd_len   = c.len;
    bus.cmd_size  = c.size;
    bus.cmd_lock  = c.lock;
    bus.cmd_cache = c.cache;
    bus.cmd_prot  = c.prot;
    exp_cmd_q.push_back(c);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_beat();
    beat_t b;
    b.data = {$urandom, $urandom};
    b.strb = SW'($urandom);
    bus.wd_valid = 1'b1;
    bus.wd_data  = b.data;
    bus.wd_strb  = b.strb;
    exp_beat_q.push_back(b);
    tick();
    bus.wd_valid = 1'b0;
  endtask

  // AXI-master side: wait for an issued transaction, retire its beats
  // (WREADY toggling 1,0,1,0 when requested), then return a response.
  task automatic run_txn(input bit toggle, input logic [1:0] bresp);
    cmd_t c;
    int   n;
    int   guard;
    bit   rdy;
    guard = 0;
    while (issued_q.size() == 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("trn_issued", 64'(issued_q.size() != 0), 64'(1));
    if (issued_q.size() == 0) return;
    c = issued_q.pop_front();
    n = int'(c.len) + 1;
    rdy = 1'b1;
    guard = 0;
    while (n > 0 && guard < 64) begin
      bus.WVALID = 1'b1;
      bus.WREADY = rdy;
      if (exp_beat_q.size() == 0) begin
        chk("beat_avail", 64'(0), 64'(1));
      end else begin
        chk("wdata", bus.wdata_d, exp_beat_q[0].data);
        chk("wstrb", 64'(bus.wstrb_d), 64'(exp_beat_q[0].strb));
      end
      chk("aw_hold", 64'(bus.awaddr_d), 64'(c.addr));
      if (rdy) begin
        if (exp_beat_q.size() != 0) void'(exp_beat_q.pop_front());
        n--;
      end
      tick();
      if (toggle) rdy = ~rdy;
      guard++;
    end
    bus.WVALID = 1'b0;
    bus.WREADY = 1'b0;
    tick();
    chk("wait_rsp_busy", 64'(bus.busy), 64'(1));
    chk("wait_rsp_no_trn", 64'(bus.wr_trn_en), 64'(0));
    chk("wait_rsp_no_issue", 64'(issued_q.size()), 64'(0));
    bus.wr_rsp_en_d = 1'b1;
    bus.bid_d       = c.id;
    bus.bresp_d     = bresp;
    if (exp_rsp_q.size() < RSP_DEPTH) exp_rsp_q.push_back({c.id, bresp});
    else exp_ovf = 1'b1;
    tick();
    bus.wr_rsp_en_d = 1'b0;
    bus.bid_d       = '0;
    bus.bresp_d     = '0;
    chk("idle_after_rsp", 64'(bus.busy), 64'(0));
    chk("awaddr_idle", 64'(bus.awaddr_d), 64'(0));
    chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(exp_ovf));
  endtask

  task automatic pop_rsp();
    logic [5:0] e;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    if (exp_rsp_q.size() == 0) begin
      chk("rsp_expected", 64'(0), 64'(1));
      return;
    end
    e = exp_rsp_q.pop_front();
    chk("rsp_id",   64'(bus.rsp_id),   64'(e[5:2]));
    chk("rsp_resp", 64'(bus.rsp_resp), 64'(e[1:0]));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int guard;
    ARst = 1'b0;
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_id = '0; bus.cmd_burst = '0;
    bus.cmd_len = '0; bus.cmd_size = '0; bus.cmd_lock = '0; bus.cmd_cache = '0;
    bus.cmd_prot = '0; bus.wd_valid = 0; bus.wd_data = '0; bus.wd_strb = '0;
    bus.WVALID = 0; bus.WREADY = 0; bus.bresp_d = '0; bus.bid_d = '0;
    bus.wr_rsp_en_d = 0; bus.rsp_ready = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("rst_wd_ready",  64'(bus.wd_ready),  64'(1));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_busy",      64'(bus.busy),      64'(0));
    chk("rst_trn_en",    64'(bus.wr_trn_en), 64'(0));
    chk("rst_rsp_ovf",   64'(bus.rsp_ovf),   64'(0));
    chk("rst_awaddr",    64'(bus.awaddr_d),  64'(0));
    chk("rst_wdata",     bus.wdata_d,        64'(0));
    ARst = 1'b1;
    tick();

    // Stray response strobe while idle is ignored
    bus.wr_rsp_en_d = 1'b1; bus.bid_d = 4'd7;
    tick();
    bus.wr_rsp_en_d = 1'b0; bus.bid_d = '0;
    tick();
    chk("stray_rsp_ignored", 64'(bus.rsp_valid), 64'(0));
    chk("stray_rsp_idle",    64'(bus.busy),      64'(0));

    // 1. Single beat with fixed data
    push_cmd(mk_cmd(32'h1000, 4'd3, 4'd0));
    bus.wd_valid = 1'b1; bus.wd_data = 64'hA5A5_A5A5_A5A5_A5A5; bus.wd_strb = 8'hFF;
    exp_beat_q.push_back({64'hA5A5_A5A5_A5A5_A5A5, 8'hFF});
    tick();
    bus.wd_valid = 1'b0;
    run_txn(1'b0, 2'b00);
    chk("t1_trn_count", 64'(trn_cnt), 64'(1));
    pop_rsp();

    // 2. Data starvation, then issue once the burst is complete
    push_cmd(mk_cmd(32'h2000, 4'd5, 4'd3));
    push_beat();
    push_beat();
    n0 = trn_cnt;
    repeat (6) tick();
    chk("starve_no_trn", 64'(trn_cnt), 64'(n0));
    chk("starve_busy",   64'(bus.busy), 64'(1));
    push_beat();
    push_beat();
    chk("starve_not_yet", 64'(bus.wr_trn_en), 64'(0));
    tick();
    chk("starve_issue", 64'(bus.wr_trn_en), 64'(1));
    run_txn(1'b0, 2'b01);
    pop_rsp();

    // 3. Back-pressure: WREADY toggling
    push_cmd(mk_cmd(32'h3000, 4'd6, 4'd3));
    for (int i = 0; i < 4; i++) push_beat();
    run_txn(1'b1, 2'b00);
    pop_rsp();

    // 4. Back-to-back: four queued commands of two beats each
    for (int i = 0; i < 4; i++) push_cmd(mk_cmd(32'h4000 + 32'(i) * 32'h40, 4'(4 + i), 4'd1));
    chk("cmd_full", 64'(bus.cmd_ready), 64'(0));
    for (int i = 0; i < 8; i++) push_beat();
    for (int i = 0; i < 4; i++) run_txn(i[0], 2'(i));
    for (int i = 0; i < 4; i++) pop_rsp();
    chk("b2b_rsp_empty", 64'(bus.rsp_valid), 64'(0));

    // 5. Response overflow with rsp_ready held low
    for (int i = 0; i < 5; i++) begin
      push_cmd(mk_cmd(32'h5000 + 32'(i) * 32'h10, 4'(8 + i), 4'd0));
      push_beat();
      run_txn(1'b0, 2'(i + 1));
    end
    chk("ovf_set", 64'(bus.rsp_ovf), 64'(1));
    for (int i = 0; i < 3; i++) pop_rsp();

    // 6. Reset in the middle of a burst
    push_cmd(mk_cmd(32'h6000, 4'd14, 4'd3));
    for (int i = 0; i < 4; i++) push_beat();
    guard = 0;
    while (issued_q.size() == 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("t6_issued", 64'(issued_q.size() != 0), 64'(1));
    bus.WVALID = 1'b1; bus.WREADY = 1'b1;
    tick();
    bus.WVALID = 1'b0; bus.WREADY = 1'b0;
    chk("t6_busy_pre",      64'(bus.busy),      64'(1));
    chk("t6_rsp_valid_pre", 64'(bus.rsp_valid), 64'(1));
    ARst = 1'b0;
    tick();
    ARst = 1'b1;
    exp_cmd_q.delete();
    issued_q.delete();
    exp_beat_q.delete();
    exp_rsp_q.delete();
    exp_ovf = 1'b0;
    chk("t6_busy",      64'(bus.busy),      64'(0));
    chk("t6_trn_en",    64'(bus.wr_trn_en), 64'(0));
    chk("t6_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("t6_wd_ready",  64'(bus.wd_ready),  64'(1));
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t6_rsp_ovf",   64'(bus.rsp_ovf),   64'(0));
    chk("t6_awaddr",    64'(bus.awaddr_d),  64'(0));
    chk("t6_wdata",     bus.wdata_d,        64'(0));
    tick();
    chk("t6_stays_idle", 64'(bus.busy), 64'(0));

    // Fresh transaction after reset sees none of the discarded state
    push_cmd(mk_cmd(32'h7000, 4'd9, 4'd0));
    push_beat();
    run_txn(1'b0, 2'b11);
    pop_rsp();
    chk("final_rsp_empty", 64'(bus.rsp_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_wr_req_sequencer.md
Name: axi_wr_req_sequencer

Overview:
- Upstream feeder for the AXI master write-control stage.
- Buffers write commands and write-data beats in two synchronous FIFOs, then issues one transaction at a time to the master through its decoder interface (address/control fields, wdata/wstrb, wr_trn_en).
- Advances data beats on observed bus handshakes.
- Captures the master's write response (bresp_d/bid_d/wr_rsp_en_d) into a response FIFO for the user.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, data width; power of two, 8..1024.
- STRB_WIDTH, DATA_WIDTH/8, strobe width.
- CMD_DEPTH, 4, command FIFO entries; power of two, ≥2.
- DATA_DEPTH, 32, data FIFO entries; power of two, ≥16.
- RSP_DEPTH, 4, response FIFO entries; power of two, ≥2.

Ports:
- AClk  in  1  clock, rising edge.
- ARst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  command FIFO not full.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_id  in  4  transaction ID.
- cmd_burst  in  2  burst type.
- cmd_len  in  4  beats minus one.
- cmd_size  in  3  beat size.
- cmd_lock  in  2  lock field.
- cmd_cache  in  2  cache field.
- cmd_prot  in  3  prot field.
- wd_valid  in  1  data push request.
- wd_ready  out  1  data FIFO not full.
- wd_data  in  DATA_WIDTH  beat data.
- wd_strb  in  STRB_WIDTH  beat strobes.
- awaddr_d  out  ADDR_WIDTH  to master.
- TXN_ID_W_d  out  4  to master.
- awburst_d  out  2  to master.
- awlen_d  out  4  to master.
- awsize_d  out  3  to master.
- awlock_d  out  2  to master.
- awcache_d  out  2  to master.
- awprot_d  out  3  to master.
- wdata_d  out  DATA_WIDTH  head-of-FIFO data to master.
- wstrb_d  out  STRB_WIDTH  head-of-FIFO strobes to master.
- wr_trn_en  out  1  one-cycle transaction start pulse.
- WVALID  in  1  bus tap.
- WREADY  in  1  bus tap.
- bresp_d  in  2  response from master.
- bid_d  in  4  response ID from master.
- wr_rsp_en_d  in  1  response strobe from master.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  response pop.
- rsp_id  out  4  head response ID.
- rsp_resp  out  2  head response code.
- busy  out  1  FSM not in IDLE.
- rsp_ovf  out  1  sticky response-overflow flag.

Behaviour:
- Reset (ARst=0 at a rising AClk edge):
  - All FIFO pointers and counts to 0; FSM to IDLE.
  - All address/control/data outputs 0; wr_trn_en 0; busy 0; rsp_ovf 0.
  - cmd_ready 1, wd_ready 1, rsp_valid 0.
  - Reset mid-transaction discards all buffered commands, data and responses with no further outputs.
- FIFOs:
  - Push on valid&&ready; write takes effect next cycle.
  - Push and pop of the same FIFO in one cycle are allowed when non-empty; count unchanged.
  - Push when full is impossible by handshake.
  - Pop is blocked when empty.
- FSM states: IDLE, WAIT_DATA, ISSUE, BURST, WAIT_RSP.
  - IDLE: if command FIFO is non-empty → WAIT_DATA.
  - WAIT_DATA: when data_count ≥ head cmd_len+1 → ISSUE. No partial bursts are ever issued.
  - ISSUE: wr_trn_en=1 for exactly this one cycle; beat counter loaded with cmd_len+1; → BURST.
  - BURST: on each cycle with WVALID&&WREADY, pop one data entry and decrement the counter. When the counter reaches 0 → WAIT_RSP.
  - WAIT_RSP: on wr_rsp_en_d=1, pop the head command, push {bid_d, bresp_d} into the response FIFO, → IDLE.
- Head-command fields on awaddr_d..awprot_d are driven registered from the command FIFO head. They are held stable from ISSUE through WAIT_RSP and are 0 in IDLE.
- wdata_d/wstrb_d always reflect the current data-FIFO head. They advance the cycle after each WVALID&&WREADY.
- Response FIFO full at wr_rsp_en_d: the response is dropped, rsp_ovf is set sticky until reset, and the command is still popped.
- A wr_rsp_en_d outside WAIT_RSP is ignored.
- busy = (state != IDLE).
- Beat counter is 5 bits; cmd_len 15 gives 16 beats.

Optional Feature:
- Macro AXI_WR_SEQ_TIMEOUT_EN.
- When defined:
  - Adds a 16-bit watchdog counter, cleared on entry to BURST and on every WVALID&&WREADY, incremented in BURST and WAIT_RSP.
  - On reaching 16'hFFFF: pop the head command and flush its remaining data beats (one per cycle), push {head id, 2'b10} as a synthesized SLVERR response, return to IDLE.
  - Adds output port timeout_err (1 bit), sticky until reset.
- When undefined: no counter and no port; the FSM waits indefinitely.

Test Plan:
1. Single beat: push cmd {addr 0x1000, id 3, len 0, burst INCR}, push data 0xA5A5_A5A5_A5A5_A5A5 strb 0xFF → one wr_trn_en pulse; after one WVALID&&WREADY and wr_rsp_en_d with bresp 00/bid 3 → rsp_valid=1, rsp_id=3, rsp_resp=00.
2. Data starvation: push cmd len 3 with only 2 beats → FSM stays in WAIT_DATA and wr_trn_en stays 0. Push 2 more beats → ISSUE the next cycle.
3. Back-pressure: 4-beat burst with WREADY toggling 1,0,1,0,… → wdata_d advances only after handshake cycles; data_count goes 4→0 after exactly 4 handshakes.
4. Back-to-back: queue 4 commands of 2 beats each → 4 wr_trn_en pulses in order, each issued only after the previous wr_rsp_en_d; responses pop in order with matching IDs.
5. Response overflow: hold rsp_ready=0 through 5 completed transactions (RSP_DEPTH 4) → rsp_ovf=1 and the 5th response is dropped.
6. Reset mid-burst: drive ARst=0 during BURST → next cycle busy=0, wr_trn_en=0, cmd_ready=1, rsp_valid=0, all FIFOs empty.
